dmem_arbiter: RTL and testbench

// - Shares the single-port data memory / MMIO bus (MemRead, MemWrite, addr, wdata, rdata) between two masters.
// - m0 = CPU load/store port, m1 = UART boot-loader / DMA engine.
// - Registered owner selection, bounded burst length and optional lock. rdata is returned registered with an rvalid pulse.
// - Sits between the masters and the data memory; the memory itself is unchanged.

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encodings, hold
// counter sizing and the burst-length range check.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } owner_e;

  localparam logic       MST_M0   = 1'b0;
  localparam logic       MST_M1   = 1'b1;
  localparam int         HOLD_W   = 8;
  localparam logic [7:0] HOLD_MAX = 8'd255;

  function automatic bit burst_ok(input int max_burst);
    return (max_burst >= 1) && (max_burst <= 255);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory / MMIO bus with bounded
// bursts, optional lock and registered read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int RR        = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (!burst_ok(MAX_BURST)) begin : g_bad_max_burst
    $error("dmem_arbiter: MAX_BURST must be in 1..255");
  end

  owner_e            owner_reg, owner_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next, hold_inc;
  logic              last_reg, last_next;
  logic              burst_done;
  logic              rvalid0_reg, rvalid1_reg;
  logic [DW-1:0]     rdata0_reg, rdata1_reg;

  // Grants are masked by rst so nothing reaches the bus in a reset cycle.
  assign m0_gnt = ~rst & (owner_reg == ST_OWN0) & m0_req;
  assign m1_gnt = ~rst & (owner_reg == ST_OWN1) & m1_req;

  assign hold_inc   = (hold_cnt_reg == HOLD_MAX) ? HOLD_MAX : hold_cnt_reg + 8'd1;
  assign burst_done = ({1'b0, hold_cnt_reg} + 9'd1) >= 9'(MAX_BURST);

  always_comb begin
    owner_next    = owner_reg;
    hold_cnt_next = hold_cnt_reg;
    case (owner_reg)
      ST_IDLE: begin
        hold_cnt_next = '0;
        if (m0_req && m1_req)
          owner_next = ((RR == 0) || (last_reg == MST_M1)) ? ST_OWN0 : ST_OWN1;
        else if (m0_req)
          owner_next = ST_OWN0;
        else if (m1_req)
          owner_next = ST_OWN1;
        else
          owner_next = ST_IDLE;
      end
      ST_OWN0: begin
        if (m0_req) begin
          if (m1_req && !m0_lock && burst_done) begin
            owner_next    = ST_OWN1;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_inc;
          end
        end else begin
          owner_next    = m1_req ? ST_OWN1 : ST_IDLE;
          hold_cnt_next = '0;
        end
      end
      ST_OWN1: begin
        if (m1_req) begin
          if (m0_req && !m1_lock && burst_done) begin
            owner_next    = ST_OWN0;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_inc;
          end
        end else begin
          owner_next    = m0_req ? ST_OWN0 : ST_IDLE;
          hold_cnt_next = '0;
        end
      end
      default: begin
        owner_next    = ST_IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  assign last_next = m1_gnt ? MST_M1 : (m0_gnt ? MST_M0 : last_reg);

  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      MemRead   = ~m0_we;
      MemWrite  = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      MemRead   = ~m1_we;
      MemWrite  = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      last_reg     <= MST_M1;
      rvalid0_reg  <= 1'b0;
      rvalid1_reg  <= 1'b0;
      rdata0_reg   <= '0;
      rdata1_reg   <= '0;
    end else begin
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
      last_reg     <= last_next;
      rvalid0_reg  <= m0_gnt & ~m0_we;
      rvalid1_reg  <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) rdata0_reg <= mem_rdata;
      if (m1_gnt && !m1_we) rdata1_reg <= mem_rdata;
    end
  end

  // A read return already in flight when rst rises is cancelled here.
  assign m0_rvalid = rvalid0_reg & ~rst;
  assign m1_rvalid = rvalid1_reg & ~rst;
  assign m0_rdata  = rst ? '0 : rdata0_reg;
  assign m1_rdata  = rst ? '0 : rdata1_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus hand sequences for
// contention, lock, reset mid-burst and round-robin tie-break.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        a_g0, a_g1, a_rv0, a_rv1, a_mr, a_mw;
  logic [31:0] a_rd0, a_rd1, a_ma, a_md, a_mrd;
  logic        b_g0, b_g1, b_rv0, b_rv1, b_mr, b_mw;
  logic [31:0] b_rd0, b_rd1, b_ma, b_md, b_mrd;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  assign a_mrd = mem_model(a_ma);
  assign b_mrd = mem_model(b_ma);

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4), .RR(0)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_gnt(a_g0), .m0_rvalid(a_rv0), .m0_rdata(a_rd0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(a_g1), .m1_rvalid(a_rv1), .m1_rdata(a_rd1),
    .MemRead(a_mr), .MemWrite(a_mw), .mem_addr(a_ma), .mem_wdata(a_md), .mem_rdata(a_mrd)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4), .RR(1)) u_dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_gnt(b_g0), .m0_rvalid(b_rv0), .m0_rdata(b_rd0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(b_g1), .m1_rvalid(b_rv1), .m1_rdata(b_rd1),
    .MemRead(b_mr), .MemWrite(b_mw), .mem_addr(b_ma), .mem_wdata(b_md), .mem_rdata(b_mrd)
  );

  typedef struct {
    logic        rst;
    logic        r0, we0;
    logic [31:0] a0, d0;
    logic        r1, we1;
    logic [31:0] a1, d1;
    logic        g0, g1, mr, mw;
    logic [31:0] ma, md;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  vec_t vecs[7];
  sb_t  sbq[2][$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d, input logic lk);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_lock = lk;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lk;
    end
  endtask

  task automatic sb_check(input int m, input logic rv, input logic [31:0] rd);
    logic exp_rv;
    exp_rv = (sbq[m].size() > 0) && (sbq[m][0].due == cyc);
    chk($sformatf("m%0d_rvalid", m), 32'(rv), 32'(exp_rv));
    if (exp_rv) begin
      if (rv) chk($sformatf("m%0d_rdata", m), rd, sbq[m][0].data);
      void'(sbq[m].pop_front());
    end
  endtask

  // Inputs are already driven; check this cycle's outputs, then advance.
  task automatic run_cycle(input string tag, input logic e_g0, input logic e_g1,
                           input logic chk_mem = 1'b0, input logic e_mr = 1'b0,
                           input logic e_mw = 1'b0, input logic [31:0] e_ma = '0,
                           input logic [31:0] e_md = '0, input logic chk_rr = 1'b0,
                           input logic rr_g0 = 1'b0, input logic rr_g1 = 1'b0);
    #1;
    if (rst) begin
      sbq[0].delete();
      sbq[1].delete();
    end
    chk({tag, " m0_gnt"}, 32'(a_g0), 32'(e_g0));
    chk({tag, " m1_gnt"}, 32'(a_g1), 32'(e_g1));
    sb_check(0, a_rv0, a_rd0);
    sb_check(1, a_rv1, a_rd1);
    if (chk_mem) begin
      chk({tag, " MemRead"}, 32'(a_mr), 32'(e_mr));
      chk({tag, " MemWrite"}, 32'(a_mw), 32'(e_mw));
      chk({tag, " mem_addr"}, a_ma, e_ma);
      chk({tag, " mem_wdata"}, a_md, e_md);
    end
    if (chk_rr) begin
      chk({tag, " rr m0_gnt"}, 32'(b_g0), 32'(rr_g0));
      chk({tag, " rr m1_gnt"}, 32'(b_g1), 32'(rr_g1));
    end
    if (e_g0 && !m0_we) sbq[0].push_back('{mem_model(m0_addr), cyc + 1});
    if (e_g1 && !m1_we) sbq[1].push_back('{mem_model(m1_addr), cyc + 1});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4000000C, 32'hA5,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4000000C, 32'hA5,
                1'b0, 1'b1, 1'b0, 1'b1, 32'h4000000C, 32'hA5};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;

    // Reset, single read, write pass-through
    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst;
      set_m(0, vecs[i].r0, vecs[i].we0, vecs[i].a0, vecs[i].d0, 1'b0);
      set_m(1, vecs[i].r1, vecs[i].we1, vecs[i].a1, vecs[i].d1, 1'b0);
      run_cycle($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, 1'b1,
                vecs[i].mr, vecs[i].mw, vecs[i].ma, vecs[i].md);
    end

    // Continuous contention: 4 grants each, alternating
    set_m(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
    run_cycle("cont idle", 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      run_cycle($sformatf("cont%0d", k), ((k / 4) % 2) == 0, ((k / 4) % 2) == 1);
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_cycle("cont rel", 1'b0, 1'b0);
    run_cycle("cont rel2", 1'b0, 1'b0);

    // Lock holds m0 past MAX_BURST; m1 owns right after lock drops
    set_m(0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1);
    set_m(1, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
    run_cycle("lock idle", 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) run_cycle($sformatf("lock%0d", k), 1'b1, 1'b0);
    m0_lock = 1'b0;
    run_cycle("unlock", 1'b1, 1'b0);
    run_cycle("unlock m1", 1'b0, 1'b1);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_cycle("lock rel", 1'b0, 1'b0);
    run_cycle("lock rel2", 1'b0, 1'b0);

    // Reset mid-burst cancels the access and the pending rvalid
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    run_cycle("rstmb idle", 1'b0, 1'b0);
    run_cycle("rstmb gnt", 1'b1, 1'b0);
    rst = 1'b1;
    run_cycle("rstmb rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    run_cycle("rstmb post", 1'b0, 1'b0);
    run_cycle("rstmb regnt", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    m0_req = 1'b0;
    run_cycle("rstmb rel", 1'b0, 1'b0);

    // Tie from IDLE after m0 served last: RR=1 picks m1, RR=0 picks m0
    set_m(0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0);
    run_cycle("rr m0 idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_cycle("rr m0 gnt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    m0_req = 1'b0;
    run_cycle("rr rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    set_m(0, 1'b1, 1'b0, 32'h600, 32'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h700, 32'h0, 1'b0);
    run_cycle("rr tie idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    run_cycle("rr tie", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_cycle("end rel", 1'b0, 1'b0);
    run_cycle("end rel2", 1'b0, 1'b0);

    chk("scoreboard m0 drained", 32'(sbq[0].size()), 32'd0);
    chk("scoreboard m1 drained", 32'(sbq[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
